// File: rtl/axil_mem_ctrl.sv
// axil_mem_ctrl: AXI4-Lite slave in front of an external boot ROM and an
// internal inferred RAM. A single access engine serves one transaction at a
// time; reads and writes contending in IDLE are arbitrated round-robin.
//
// Address map (addr[31:28]): 0 = ROM, 1 = RAM, others = DECERR.
//
// Ports:
//   CLK, RSTb              clock, synchronous active-low reset
//   s_aw*/s_w*/s_b*        AXI4-Lite write address/data/response channels
//   s_ar*/s_r*             AXI4-Lite read address/data channels
//   rom_addr, rom_req      ROM word address and one-cycle request pulse
//   rom_data, rom_valid    ROM response (variable latency, one-cycle valid)
module axil_mem_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          RAM_AW      = 10,
    parameter int          ROM_AW      = 10,
    parameter int          ROM_TIMEOUT = 16,
    parameter logic [31:0] ERR_PATTERN = 32'hDEADBEEF
) (
    input  logic                CLK,
    input  logic                RSTb,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [31:0]         s_awaddr,
    input  logic [2:0]          s_awprot,
    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [1:0]          s_bresp,
    input  logic                s_arvalid,
    output logic                s_arready,
    input  logic [31:0]         s_araddr,
    input  logic [2:0]          s_arprot,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic [ROM_AW-1:0]   rom_addr,
    output logic                rom_req,
    input  logic [DATA_W-1:0]   rom_data,
    input  logic                rom_valid
);
    localparam int STRB_W = DATA_W / 8;
    // Byte-offset bits of one DATA_W word: 2 + log2(DATA_W/32).
    localparam int OFS    = 2 + $clog2(DATA_W / 32);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [DATA_W-1:0] ERR_DATA = {(DATA_W/32){ERR_PATTERN}};
    localparam logic [7:0] TMO_LAST = 8'(ROM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, AR_ACC, RD_RAM, RD_ROM, RD_RESP, W_ACC, W_RAM, WR_RESP
    } state_t;

    state_t              state, state_nxt;
    logic                pri_rd;      // 1: read wins the next tie
    logic                grant_rd, grant_wr;
    logic                wr_elig;
    logic [RAM_AW-1:0]   ram_idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [7:0]          cnt;
    logic [DATA_W-1:0]   mem [2**RAM_AW];

    // Prot fields and undecoded address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_awprot, s_arprot, s_awaddr, s_araddr};

    assign wr_elig   = s_awvalid && s_wvalid;
    assign s_arready = (state == AR_ACC);
    assign s_awready = (state == W_ACC);
    assign s_wready  = (state == W_ACC);
    assign s_rvalid  = (state == RD_RESP);
    assign s_bvalid  = (state == WR_RESP);

    always_ff @(posedge CLK) begin
        if (!RSTb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        case (state)
            IDLE: begin
                if (s_arvalid && (!wr_elig || pri_rd)) begin
                    grant_rd  = 1'b1;
                    state_nxt = AR_ACC;
                end else if (wr_elig) begin
                    grant_wr  = 1'b1;
                    state_nxt = W_ACC;
                end
            end
            AR_ACC: begin
                case (s_araddr[31:28])
                    4'h0:    state_nxt = RD_ROM;
                    4'h1:    state_nxt = RD_RAM;
                    default: state_nxt = RD_RESP;
                endcase
            end
            RD_RAM:  state_nxt = RD_RESP;
            RD_ROM:  if (rom_valid || cnt == TMO_LAST) state_nxt = RD_RESP;
            RD_RESP: if (s_rready) state_nxt = IDLE;
            W_ACC:   state_nxt = (s_awaddr[31:28] == 4'h1) ? W_RAM : WR_RESP;
            W_RAM:   state_nxt = WR_RESP;
            WR_RESP: if (s_bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            pri_rd    <= 1'b1;
            rom_req   <= 1'b0;
            rom_addr  <= '0;
            s_rdata   <= '0;
            s_rresp   <= OKAY;
            s_bresp   <= OKAY;
            cnt       <= '0;
            ram_idx_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            rom_req <= 1'b0;
            // Pointer tracks the last grant so the other side wins a tie.
            if (grant_rd) pri_rd <= 1'b0;
            if (grant_wr) pri_rd <= 1'b1;
            case (state)
                AR_ACC: begin
                    ram_idx_q <= s_araddr[OFS +: RAM_AW];
                    cnt       <= '0;
                    case (s_araddr[31:28])
                        4'h0: begin
                            rom_req  <= 1'b1;
                            rom_addr <= s_araddr[OFS +: ROM_AW];
                        end
                        4'h1: ;
                        default: begin
                            s_rdata <= ERR_DATA;
                            s_rresp <= DECERR;
                        end
                    endcase
                end
                RD_RAM: begin
                    s_rdata <= mem[ram_idx_q];
                    s_rresp <= OKAY;
                end
                RD_ROM: begin
                    if (rom_valid) begin
                        s_rdata <= rom_data;
                        s_rresp <= OKAY;
                    end else if (cnt == TMO_LAST) begin
                        s_rdata <= ERR_DATA;
                        s_rresp <= SLVERR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                W_ACC: begin
                    ram_idx_q <= s_awaddr[OFS +: RAM_AW];
                    wdata_q   <= s_wdata;
                    wstrb_q   <= s_wstrb;
                    case (s_awaddr[31:28])
                        4'h0:    s_bresp <= SLVERR;   // ROM is read-only
                        4'h1:    ;
                        default: s_bresp <= DECERR;
                    endcase
                end
                W_RAM: s_bresp <= OKAY;
                default: ;
            endcase
        end
    end

    // RAM array has no reset so it maps onto block memory.
    always_ff @(posedge CLK) begin
        if (state == W_RAM) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb_q[b]) mem[ram_idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
    end
endmodule

// File: tb/tb_axil_mem_ctrl.sv
module tb_axil_mem_ctrl;
    logic        CLK = 1'b0;
    logic        RSTb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, rom_data;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [9:0]  rom_addr;
    logic        rom_req, rom_valid;

    int n_cmp = 0;
    int n_err = 0;

    // ROM model controls
    logic        rom_en = 1'b0;
    int          rom_dly = 3;
    logic [31:0] rom_val = '0;
    int          rom_cd = 0;
    logic [9:0]  rom_seen = '0;

    axil_mem_ctrl dut (
        .CLK(CLK), .RSTb(RSTb),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .rom_addr(rom_addr), .rom_req(rom_req), .rom_data(rom_data), .rom_valid(rom_valid)
    );

    always #5 CLK = ~CLK;

    // Boot ROM: answers rom_dly cycles after the rom_req cycle when enabled.
    initial begin
        rom_valid = 1'b0;
        rom_data  = '0;
        forever begin
            @(posedge CLK); #1;
            rom_valid = 1'b0;
            if (rom_cd > 0) begin
                rom_cd--;
                if (rom_cd == 0) begin rom_valid = 1'b1; rom_data = rom_val; end
            end
            if (rom_req && rom_en) begin rom_cd = rom_dly; rom_seen = rom_addr; end
        end
    end

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] r, output int lat);
        int n = 0;
        logic prev = 1'b0;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        lat = -1; d = 'x; r = 'x;
        while (n < 100) begin
            @(posedge CLK); #1; n++;
            if (prev) s_arvalid = 1'b0;
            prev = s_arready;
            if (s_rvalid) begin
                d = s_rdata; r = s_rresp; lat = n;
                @(posedge CLK); #1;
                break;
            end
        end
        s_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            output logic [1:0] r, output int lat);
        int n = 0;
        logic prev = 1'b0;
        s_awaddr = a; s_wdata = wd; s_wstrb = st;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        lat = -1; r = 'x;
        while (n < 100) begin
            @(posedge CLK); #1; n++;
            if (prev) begin s_awvalid = 1'b0; s_wvalid = 1'b0; end
            prev = s_awready;
            if (s_bvalid) begin
                r = s_bresp; lat = n;
                @(posedge CLK); #1;
                break;
            end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic test_reset();
        RSTb = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({s_arready, s_awready, s_wready, s_bvalid, s_rvalid, rom_req} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {s_arready, s_awready, s_wready, s_bvalid, s_rvalid, rom_req});
        end
        n_cmp++;
        if ({s_bresp, s_rresp, s_rdata, rom_addr} !== 46'h0) begin
            n_err++;
            $display("FAIL reset_data: got bresp=%h rresp=%h rdata=%h rom_addr=%h want 0",
                     s_bresp, s_rresp, s_rdata, rom_addr);
        end
        RSTb = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_ram_strobes();
        logic [31:0] d; logic [1:0] r; int lat;
        do_write(32'h1000_0010, 32'h1122_3344, 4'hF, r, lat);
        n_cmp++;
        if (r !== 2'b00 || lat !== 3) begin
            n_err++; $display("FAIL ram_wr_full: got bresp=%h lat=%0d want 0 3", r, lat);
        end
        do_write(32'h1000_0010, 32'hAABB_CCDD, 4'b0101, r, lat);
        n_cmp++;
        if (r !== 2'b00) begin n_err++; $display("FAIL ram_wr_part: got bresp=%h want 0", r); end
        do_read(32'h1000_0010, d, r, lat);
        n_cmp++;
        if (d !== 32'h11BB_33DD || r !== 2'b00 || lat !== 3) begin
            n_err++; $display("FAIL ram_rd: got %h/%h lat=%0d want 11bb33dd/0 lat=3", d, r, lat);
        end
        do_read(32'h1000_1010, d, r, lat);
        n_cmp++;
        if (d !== 32'h11BB_33DD || r !== 2'b00) begin
            n_err++; $display("FAIL ram_wrap: got %h/%h want 11bb33dd/0", d, r);
        end
        do_write(32'h1000_0010, 32'hFFFF_FFFF, 4'h0, r, lat);
        do_read(32'h1000_0010, d, r, lat);
        n_cmp++;
        if (d !== 32'h11BB_33DD) begin
            n_err++; $display("FAIL ram_zero_strb: got %h want 11bb33dd", d);
        end
    endtask

    task automatic test_rom();
        logic [31:0] d; logic [1:0] r; int lat;
        rom_en = 1'b1; rom_dly = 3; rom_val = 32'hCAFE_F00D; rom_seen = '1;
        do_read(32'h0000_0008, d, r, lat);
        n_cmp++;
        if (rom_seen !== 10'd2) begin n_err++; $display("FAIL rom_addr: got %0d want 2", rom_seen); end
        n_cmp++;
        if (d !== 32'hCAFE_F00D || r !== 2'b00 || lat !== 6) begin
            n_err++; $display("FAIL rom_rd: got %h/%h lat=%0d want cafef00d/0 lat=6", d, r, lat);
        end
        rom_en = 1'b0;
        do_read(32'h0000_000C, d, r, lat);
        n_cmp++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b10 || lat !== 18) begin
            n_err++; $display("FAIL rom_timeout: got %h/%h lat=%0d want deadbeef/2 lat=18", d, r, lat);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] r; int lat;
        do_read(32'h2000_0000, d, r, lat);
        n_cmp++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b11 || lat !== 2) begin
            n_err++; $display("FAIL rd_decerr: got %h/%h lat=%0d want deadbeef/3 lat=2", d, r, lat);
        end
        do_write(32'h0000_0000, 32'h1234_5678, 4'hF, r, lat);
        n_cmp++;
        if (r !== 2'b10 || lat !== 2) begin
            n_err++; $display("FAIL wr_rom_slverr: got %h lat=%0d want 2 lat=2", r, lat);
        end
        rom_en = 1'b1; rom_dly = 1; rom_val = 32'h0BAD_C0DE;
        do_read(32'h0000_0004, d, r, lat);
        n_cmp++;
        if (d !== 32'h0BAD_C0DE || r !== 2'b00 || lat !== 4 || rom_seen !== 10'd1) begin
            n_err++; $display("FAIL rom_after_wr: got %h/%h lat=%0d addr=%0d want 0badc0de/0 lat=4 addr=1",
                              d, r, lat, rom_seen);
        end
        do_write(32'h3000_0000, 32'h1234_5678, 4'hF, r, lat);
        n_cmp++;
        if (r !== 2'b11 || lat !== 2) begin
            n_err++; $display("FAIL wr_decerr: got %h lat=%0d want 3 lat=2", r, lat);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] seq = '0;
        int g = 0;
        int n = 0;
        s_araddr = 32'h1000_0030; s_arvalid = 1'b1; s_rready = 1'b1;
        s_awaddr = 32'h1000_0034; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        while (g < 4 && n < 80) begin
            @(posedge CLK); #1; n++;
            if (s_arready) begin seq[g] = 1'b0; g++; end
            else if (s_awready) begin seq[g] = 1'b1; g++; end
        end
        @(posedge CLK); #1;
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        n_cmp++;
        if (g !== 4 || seq !== 4'b1010) begin
            n_err++; $display("FAIL arb_order: got grants=%0d seq=%b want 4 1010", g, seq);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0; logic [1:0] r; int lat;
        int n = 0;
        int bad = 0;
        s_araddr = 32'h1000_0010; s_arvalid = 1'b1; s_rready = 1'b0;
        while (!s_rvalid && n < 20) begin @(posedge CLK); #1; n++; end
        d0 = s_rdata;
        n_cmp++;
        if (!s_rvalid || d0 !== 32'h11BB_33DD) begin
            n_err++; $display("FAIL bp_rd_data: got rvalid=%b %h want 1 11bb33dd", s_rvalid, d0);
        end
        repeat (10) begin
            @(posedge CLK); #1;
            if (!s_rvalid || s_rdata !== d0 || s_arready) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL bp_rd_hold: got %0d bad cycles want 0", bad); end
        s_rready = 1'b1;
        @(posedge CLK); #1;
        s_arvalid = 1'b0;
        n_cmp++;
        if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL bp_rd_drop: got rvalid=%b want 0", s_rvalid); end
        @(posedge CLK); #1;

        n = 0; bad = 0;
        s_awaddr = 32'h1000_0020; s_wdata = 32'h0102_0304; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        while (!s_bvalid && n < 20) begin @(posedge CLK); #1; n++; end
        repeat (10) begin
            @(posedge CLK); #1;
            if (!s_bvalid || s_bresp !== 2'b00 || s_awready) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL bp_wr_hold: got %0d bad cycles want 0", bad); end
        s_bready = 1'b1;
        @(posedge CLK); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n_cmp++;
        if (s_bvalid !== 1'b0) begin n_err++; $display("FAIL bp_wr_drop: got bvalid=%b want 0", s_bvalid); end
        @(posedge CLK); #1;
        do_read(32'h1000_0020, d0, r, lat);
        n_cmp++;
        if (d0 !== 32'h0102_0304) begin n_err++; $display("FAIL bp_wr_data: got %h want 01020304", d0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; int lat;
        int bad = 0;
        rom_en = 1'b1; rom_dly = 3; rom_val = 32'h1234_5678;
        s_araddr = 32'h0000_0004; s_arvalid = 1'b1; s_rready = 1'b1;
        @(posedge CLK); #1;              // cycle 1: AR_ACC
        @(posedge CLK); #1;              // cycle 2: RD_ROM, rom_req
        s_arvalid = 1'b0;
        n_cmp++;
        if (rom_req !== 1'b1) begin n_err++; $display("FAIL mid_rom_req: got %b want 1", rom_req); end
        @(posedge CLK); #1;              // cycle 3: still waiting on ROM
        RSTb = 1'b0;
        @(posedge CLK); #1;
        RSTb = 1'b1;
        repeat (8) begin
            @(posedge CLK); #1;
            if (s_rvalid || s_arready || s_awready) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL mid_reset_quiet: got %0d bad cycles want 0", bad); end
        rom_en = 1'b0;
        do_write(32'h1000_0040, 32'h5A5A_A5A5, 4'hF, r, lat);
        do_read(32'h1000_0040, d, r, lat);
        n_cmp++;
        if (d !== 32'h5A5A_A5A5 || r !== 2'b00 || lat !== 3) begin
            n_err++; $display("FAIL mid_after_rd: got %h/%h lat=%0d want 5a5aa5a5/0 lat=3", d, r, lat);
        end
    endtask

    initial begin
        RSTb = 1'b0;
        s_awvalid = 0; s_awaddr = '0; s_awprot = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0;
        s_bready = 0; s_arvalid = 0; s_araddr = '0; s_arprot = '0; s_rready = 0;
        test_reset();
        test_ram_strobes();
        test_rom();
        test_errors();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
